// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcodes and the datapath select/operation codes it drives.
package mc_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit. Moore FSM stepping each instruction through
// fetch/decode/execute/memory/writeback; outputs are decoded from the state
// register (plus Op for bne and illegal detection, Zero for PCEn).
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       Illegal
);

    state_t state_q;
    logic   pc_write;
    logic   br_cond;
    logic   is_bne;
    logic   op_legal;

    assign op_legal = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                      (Op == OP_BEQ) || (Op == OP_BNE) || (Op == OP_ADDI) ||
                      (Op == OP_J);

    // State register and next-state selection; Op only steers DECODE and MEMADR.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from pre-edge values, matching the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            case (state_q)
                S_INIT:   state_q <= S_FETCH;
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW:    state_q <= S_MEMADR;
                        OP_RTYPE:        state_q <= S_EXEC;
                        OP_BEQ, OP_BNE:  state_q <= S_BRANCH;
                        OP_ADDI:         state_q <= S_ADDIEX;
                        OP_J:            state_q <= S_JUMP;
                        default:         state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_q <= S_MEMWB;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP:
                          state_q <= S_FETCH;
                default:  state_q <= S_INIT;
            endcase
        end
    end

    // Per-state output decode; INIT and unused encodings leave everything at 0.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ALUOp     = ALUOP_ADD;
        PCSource  = PCSRC_ALU;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        pc_write  = 1'b0;
        br_cond   = 1'b0;
        is_bne    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                Illegal = !op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_SUB;
                PCSource  = PCSRC_ALUOUT;
                br_cond   = 1'b1;
                is_bne    = (Op == OP_BNE);
                InstrDone = 1'b1;
            end
            S_JUMP: begin
                PCSource  = PCSRC_JUMP;
                pc_write  = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn = pc_write | (br_cond & (Zero ^ is_bne));

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. The driver pushes a hand-written expected
// output vector for every cycle it drives; a monitor pops and compares at the
// negedge (or immediately on demand, for the asynchronous reset check).
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg;
    logic       ALUSrcA, InstrDone, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    event     mon_ev;

    // {PCEn,IorD,MemWrite,IRWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,
    //  ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],InstrDone,Illegal}
    localparam logic [15:0] E_ZERO   = 16'b0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [15:0] E_FETCH  = 16'b1_0_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [15:0] E_DEC    = 16'b0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [15:0] E_DECILL = 16'b0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [15:0] E_MEMADR = 16'b0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [15:0] E_MEMRD  = 16'b0_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [15:0] E_MEMWR  = 16'b0_1_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [15:0] E_MEMWB  = 16'b0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [15:0] E_EXEC   = 16'b0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [15:0] E_ALUWB  = 16'b0_0_0_0_1_1_0_0_00_00_00_1_0;
    localparam logic [15:0] E_ADDIWB = 16'b0_0_0_0_1_0_0_0_00_00_00_1_0;
    localparam logic [15:0] E_BR_T   = 16'b1_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [15:0] E_BR_N   = 16'b0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [15:0] E_JUMP   = 16'b1_0_0_0_0_0_0_0_00_00_10_1_0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                           JMP = 6'b000010, BAD = 6'b111111;

    mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Op        (Op),
        .Zero      (Zero),
        .PCEn      (PCEn),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSource  (PCSource),
        .InstrDone (InstrDone),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    // Monitor: compare the oldest expectation against the live outputs.
    initial begin
        logic [15:0] got;
        sb_item_t    it;
        forever begin
            @(negedge clk or mon_ev);
            if (sb_q.size() > 0) begin
                it  = sb_q.pop_front();
                got = {PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg,
                       ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrDone, Illegal};
                checks++;
                if (got !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b at %0t",
                             it.name, got, it.exp, $time);
                end
            end
        end
    end

    // One clock of stimulus plus the expected outputs for that clock.
    task automatic step(input logic rst, input logic [5:0] op, input logic z,
                        input logic [15:0] e, input string nm);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst_n = rst;
        Op    = op;
        Zero  = z;
        it.name = nm;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    initial begin
        sb_item_t it;
        rst_n = 1'b0;
        Op    = 6'd0;
        Zero  = 1'b0;

        // Reset held three cycles, then one INIT cycle, then FETCH.
        for (int i = 0; i < 3; i++) step(1'b0, RT, 1'b0, E_ZERO, "reset_hold");
        step(1'b1, RT, 1'b0, E_ZERO, "init");

        // lw: five cycles, writeback only in the last.
        step(1'b1, LW, 1'b0, E_FETCH,  "lw_fetch");
        step(1'b1, LW, 1'b0, E_DEC,    "lw_decode");
        step(1'b1, LW, 1'b0, E_MEMADR, "lw_memadr");
        step(1'b1, LW, 1'b0, E_MEMRD,  "lw_memrd");
        step(1'b1, LW, 1'b0, E_MEMWB,  "lw_memwb");

        // R-type then addi; Op wiggles in EXEC/ALUWB without effect.
        step(1'b1, RT,   1'b0, E_FETCH,  "r_fetch");
        step(1'b1, RT,   1'b0, E_DEC,    "r_decode");
        step(1'b1, LW,   1'b0, E_EXEC,   "r_exec");
        step(1'b1, SW,   1'b0, E_ALUWB,  "r_aluwb");
        step(1'b1, ADDI, 1'b0, E_FETCH,  "addi_fetch");
        step(1'b1, ADDI, 1'b0, E_DEC,    "addi_decode");
        step(1'b1, ADDI, 1'b0, E_MEMADR, "addi_exec");
        step(1'b1, ADDI, 1'b0, E_ADDIWB, "addi_wb");

        // Branches: PCEn = Zero for beq, !Zero for bne.
        step(1'b1, BEQ, 1'b1, E_FETCH, "beq_z1_fetch");
        step(1'b1, BEQ, 1'b1, E_DEC,   "beq_z1_decode");
        step(1'b1, BEQ, 1'b1, E_BR_T,  "beq_z1_branch");
        step(1'b1, BNE, 1'b1, E_FETCH, "bne_z1_fetch");
        step(1'b1, BNE, 1'b1, E_DEC,   "bne_z1_decode");
        step(1'b1, BNE, 1'b1, E_BR_N,  "bne_z1_branch");
        step(1'b1, BNE, 1'b0, E_FETCH, "bne_z0_fetch");
        step(1'b1, BNE, 1'b0, E_DEC,   "bne_z0_decode");
        step(1'b1, BNE, 1'b0, E_BR_T,  "bne_z0_branch");
        step(1'b1, BEQ, 1'b0, E_FETCH, "beq_z0_fetch");
        step(1'b1, BEQ, 1'b0, E_DEC,   "beq_z0_decode");
        step(1'b1, BEQ, 1'b0, E_BR_N,  "beq_z0_branch");

        // Illegal opcode: pulse in DECODE, straight back to FETCH.
        step(1'b1, BAD, 1'b0, E_FETCH,  "ill_fetch");
        step(1'b1, BAD, 1'b0, E_DECILL, "ill_decode");

        // sw (4 cycles) and j (3 cycles).
        step(1'b1, SW,  1'b0, E_FETCH,  "sw_fetch");
        step(1'b1, SW,  1'b0, E_DEC,    "sw_decode");
        step(1'b1, SW,  1'b0, E_MEMADR, "sw_memadr");
        step(1'b1, SW,  1'b0, E_MEMWR,  "sw_memwr");
        step(1'b1, JMP, 1'b0, E_FETCH,  "j_fetch");
        step(1'b1, JMP, 1'b0, E_DEC,    "j_decode");
        step(1'b1, JMP, 1'b0, E_JUMP,   "j_jump");

        // lw aborted by reset during MEMRD: outputs drop at once, no writeback.
        step(1'b1, LW, 1'b0, E_FETCH,  "abort_fetch");
        step(1'b1, LW, 1'b0, E_DEC,    "abort_decode");
        step(1'b1, LW, 1'b0, E_MEMADR, "abort_memadr");
        step(1'b1, LW, 1'b0, E_MEMRD,  "abort_memrd");
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        #1;
        it.name = "abort_async";
        it.exp  = E_ZERO;
        sb_q.push_back(it);
        -> mon_ev;
        step(1'b0, LW, 1'b0, E_ZERO,  "abort_hold");
        step(1'b0, LW, 1'b0, E_ZERO,  "abort_hold2");
        step(1'b1, LW, 1'b0, E_ZERO,  "abort_init");
        step(1'b1, LW, 1'b0, E_FETCH, "abort_refetch");

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
